// File: rtl/x4xx_qsfp_axil_arbiter_if.sv
// AXI4-Lite channel bundle used on both the upstream requester ports and the
// downstream QSFP wrapper register port of the arbiter.
interface x4xx_qsfp_axil_arbiter_if #(
   parameter int ADDR_W = 40
);
   logic [ADDR_W-1:0] awaddr;
   logic              awvalid;
   logic              awready;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;
   logic [ADDR_W-1:0] araddr;
   logic              arvalid;
   logic              arready;
   logic [31:0]       rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/x4xx_qsfp_axil_arbiter.sv
// Two-requester, single-transaction AXI4-Lite arbiter in front of the QSFP register port.
// Optional response timeout with SLVERR completion: define QSFP_AXIL_TIMEOUT_EN.
module x4xx_qsfp_axil_arbiter #(
   parameter int ADDR_W      = 40,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                     bus_clk,
   input  logic                     bus_rst,
   x4xx_qsfp_axil_arbiter_if.slave  s0_axi,
   x4xx_qsfp_axil_arbiter_if.slave  s1_axi,
   x4xx_qsfp_axil_arbiter_if.master m_axi,
   output logic [1:0]               grant
);
`ifdef QSFP_AXIL_TIMEOUT_EN
   typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, ERR_RESP} state_t;
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_wr_q, err_wr_d;
   logic             m_hs;
`else
   typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA} state_t;
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYC == 0);
`endif

   state_t            state_q, state_d, st_o;
   logic [1:0]        grant_q, grant_d;
   logic              last_q, last_d;
   logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic              gi, sel, done;
   logic              aw_hs, w_hs, ar_hs;
   logic [1:0]        s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready;
   logic [1:0]        wr_pend, pend;
   logic [1:0]        s_awready, s_wready, s_arready, s_bvalid, s_rvalid;
   logic [1:0][1:0]   s_bresp, s_rresp;
   logic [1:0][31:0]  s_rdata;
   logic              m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready;
   logic [ADDR_W-1:0] m_awaddr, m_araddr;

   assign gi        = grant_q[1];
   assign grant     = grant_q;
   assign s_awvalid = {s1_axi.awvalid, s0_axi.awvalid};
   assign s_wvalid  = {s1_axi.wvalid,  s0_axi.wvalid};
   assign s_arvalid = {s1_axi.arvalid, s0_axi.arvalid};
   assign s_bready  = {s1_axi.bready,  s0_axi.bready};
   assign s_rready  = {s1_axi.rready,  s0_axi.rready};
   assign wr_pend   = s_awvalid & s_wvalid;
   assign pend      = wr_pend | s_arvalid;
   // Port that was not served last has priority.
   assign sel       = pend[~last_q] ? ~last_q : last_q;

   assign m_awaddr      = gi ? s1_axi.awaddr : s0_axi.awaddr;
   assign m_araddr      = gi ? s1_axi.araddr : s0_axi.araddr;
   assign m_axi.awaddr  = m_awaddr;
   assign m_axi.araddr  = m_araddr;
   assign m_axi.wdata   = gi ? s1_axi.wdata : s0_axi.wdata;
   assign m_axi.wstrb   = gi ? s1_axi.wstrb : s0_axi.wstrb;
   assign m_axi.awvalid = m_awvalid;
   assign m_axi.wvalid  = m_wvalid;
   assign m_axi.arvalid = m_arvalid;
   assign m_axi.bready  = m_bready;
   assign m_axi.rready  = m_rready;

   assign s0_axi.awready = s_awready[0];
   assign s0_axi.wready  = s_wready[0];
   assign s0_axi.arready = s_arready[0];
   assign s0_axi.bvalid  = s_bvalid[0];
   assign s0_axi.bresp   = s_bresp[0];
   assign s0_axi.rvalid  = s_rvalid[0];
   assign s0_axi.rresp   = s_rresp[0];
   assign s0_axi.rdata   = s_rdata[0];
   assign s1_axi.awready = s_awready[1];
   assign s1_axi.wready  = s_wready[1];
   assign s1_axi.arready = s_arready[1];
   assign s1_axi.bvalid  = s_bvalid[1];
   assign s1_axi.bresp   = s_bresp[1];
   assign s1_axi.rvalid  = s_rvalid[1];
   assign s1_axi.rresp   = s_rresp[1];
   assign s1_axi.rdata   = s_rdata[1];

   // Outputs are decoded from an IDLE-forced state while reset is held so
   // that nothing handshakes during the reset cycle itself.
   assign st_o = bus_rst ? IDLE : state_q;

   always_comb begin
      s_awready = '0;
      s_wready  = '0;
      s_arready = '0;
      s_bvalid  = '0;
      s_rvalid  = '0;
      s_bresp   = '0;
      s_rresp   = '0;
      s_rdata   = '0;
      m_awvalid = 1'b0;
      m_wvalid  = 1'b0;
      m_arvalid = 1'b0;
      m_bready  = 1'b0;
      m_rready  = 1'b0;
      case (st_o)
         WR_ADDR: begin
            m_awvalid     = s_awvalid[gi] & ~aw_done_q;
            m_wvalid      = s_wvalid[gi] & ~w_done_q;
            s_awready[gi] = m_axi.awready & ~aw_done_q;
            s_wready[gi]  = m_axi.wready & ~w_done_q;
         end
         WR_RESP: begin
            m_bready     = s_bready[gi];
            s_bvalid[gi] = m_axi.bvalid;
            s_bresp[gi]  = m_axi.bresp;
         end
         RD_ADDR: begin
            m_arvalid     = s_arvalid[gi];
            s_arready[gi] = m_axi.arready;
         end
         RD_DATA: begin
            m_rready     = s_rready[gi];
            s_rvalid[gi] = m_axi.rvalid;
            s_rresp[gi]  = m_axi.rresp;
            s_rdata[gi]  = m_axi.rdata;
         end
`ifdef QSFP_AXIL_TIMEOUT_EN
         ERR_RESP: begin
            if (err_wr_q) begin
               s_bvalid[gi] = 1'b1;
               s_bresp[gi]  = 2'b10;
            end else begin
               s_rvalid[gi] = 1'b1;
               s_rresp[gi]  = 2'b10;
               s_rdata[gi]  = 32'hDEAD_BEEF;
            end
         end
`endif
         default: ;
      endcase
   end

   assign aw_hs = m_awvalid & m_axi.awready;
   assign w_hs  = m_wvalid & m_axi.wready;
   assign ar_hs = m_arvalid & m_axi.arready;
   assign done  = (s_bvalid[gi] & s_bready[gi]) | (s_rvalid[gi] & s_rready[gi]);
`ifdef QSFP_AXIL_TIMEOUT_EN
   assign m_hs  = aw_hs | w_hs | ar_hs | (m_axi.bvalid & m_bready) | (m_axi.rvalid & m_rready);
`endif

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      last_d    = last_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
`ifdef QSFP_AXIL_TIMEOUT_EN
      cnt_d     = cnt_q;
      err_wr_d  = err_wr_q;
`endif
      case (state_q)
         IDLE: begin
            if (|pend) begin
               grant_d = sel ? 2'b10 : 2'b01;
               state_d = wr_pend[sel] ? WR_ADDR : RD_ADDR;
            end
         end
         WR_ADDR: begin
            aw_done_d = aw_done_q | aw_hs;
            w_done_d  = w_done_q | w_hs;
            if (aw_done_d && w_done_d) begin
               state_d   = WR_RESP;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end
         end
         RD_ADDR: if (ar_hs) state_d = RD_DATA;
         default: begin
            if (done) begin
               state_d = IDLE;
               grant_d = 2'b00;
               last_d  = gi;
            end
         end
      endcase
`ifdef QSFP_AXIL_TIMEOUT_EN
      if (state_q == IDLE || state_q == ERR_RESP || m_hs) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
         cnt_d     = '0;
         state_d   = ERR_RESP;
         err_wr_d  = (state_q == WR_ADDR) || (state_q == WR_RESP);
         aw_done_d = 1'b0;
         w_done_d  = 1'b0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
`endif
   end

   always_ff @(posedge bus_clk) begin
      if (bus_rst) begin
         state_q   <= IDLE;
         grant_q   <= 2'b00;
         last_q    <= 1'b1;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
`ifdef QSFP_AXIL_TIMEOUT_EN
         cnt_q     <= '0;
         err_wr_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
`ifdef QSFP_AXIL_TIMEOUT_EN
         cnt_q     <= cnt_d;
         err_wr_q  <= err_wr_d;
`endif
      end
   end
endmodule

// File: tb/tb_x4xx_qsfp_axil_arbiter.sv
// Directed bench: transaction-level arbitration model plus master responder,
// compared against the DUT every cycle.
module tb_x4xx_qsfp_axil_arbiter;
   localparam int AW = 40;

   logic bus_clk = 1'b0;
   logic bus_rst = 1'b1;
   always #5 bus_clk = ~bus_clk;

   x4xx_qsfp_axil_arbiter_if #(.ADDR_W(AW)) s0_if ();
   x4xx_qsfp_axil_arbiter_if #(.ADDR_W(AW)) s1_if ();
   x4xx_qsfp_axil_arbiter_if #(.ADDR_W(AW)) m_if ();
   logic [1:0] grant;

   x4xx_qsfp_axil_arbiter #(.ADDR_W(AW), .TIMEOUT_CYC(16)) dut (
      .bus_clk(bus_clk), .bus_rst(bus_rst),
      .s0_axi(s0_if), .s1_axi(s1_if), .m_axi(m_if), .grant(grant)
   );

   // requester stimulus
   logic [1:0]    s_awv = '0, s_wv = '0, s_arv = '0;
   logic [AW-1:0] s_awaddr [2];
   logic [AW-1:0] s_araddr [2];
   logic [31:0]   s_wdata  [2];
   logic [3:0]    s_wstrb  [2];
   assign s0_if.awaddr = s_awaddr[0]; assign s1_if.awaddr = s_awaddr[1];
   assign s0_if.araddr = s_araddr[0]; assign s1_if.araddr = s_araddr[1];
   assign s0_if.wdata  = s_wdata[0];  assign s1_if.wdata  = s_wdata[1];
   assign s0_if.wstrb  = s_wstrb[0];  assign s1_if.wstrb  = s_wstrb[1];
   assign s0_if.awvalid = s_awv[0];   assign s1_if.awvalid = s_awv[1];
   assign s0_if.wvalid  = s_wv[0];    assign s1_if.wvalid  = s_wv[1];
   assign s0_if.arvalid = s_arv[0];   assign s1_if.arvalid = s_arv[1];
   assign s0_if.bready = 1'b1; assign s1_if.bready = 1'b1;
   assign s0_if.rready = 1'b1; assign s1_if.rready = 1'b1;

   logic [1:0]  o_awready, o_wready, o_arready, o_bvalid, o_rvalid;
   logic [1:0]  o_bresp [2];
   logic [1:0]  o_rresp [2];
   logic [31:0] o_rdata [2];
   assign o_awready = {s1_if.awready, s0_if.awready};
   assign o_wready  = {s1_if.wready,  s0_if.wready};
   assign o_arready = {s1_if.arready, s0_if.arready};
   assign o_bvalid  = {s1_if.bvalid,  s0_if.bvalid};
   assign o_rvalid  = {s1_if.rvalid,  s0_if.rvalid};
   assign o_bresp[0] = s0_if.bresp; assign o_bresp[1] = s1_if.bresp;
   assign o_rresp[0] = s0_if.rresp; assign o_rresp[1] = s1_if.rresp;
   assign o_rdata[0] = s0_if.rdata; assign o_rdata[1] = s1_if.rdata;

   // downstream responder
   logic        m_awready = 0, m_wready = 0, m_arready = 0, m_bvalid = 0, m_rvalid = 0;
   logic [31:0] m_rdata = '0;
   assign m_if.awready = m_awready; assign m_if.wready = m_wready;
   assign m_if.arready = m_arready; assign m_if.bvalid = m_bvalid;
   assign m_if.rvalid  = m_rvalid;  assign m_if.rdata  = m_rdata;
   assign m_if.bresp = 2'b00; assign m_if.rresp = 2'b00;
   int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
   int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
   bit b_pend = 0, r_pend = 0, r_never = 0;
   logic [31:0] r_val = '0;
   int r_seq = 0;

   // model state
   int tests = 0, fails = 0;
   int owner = -1, cyc = 0, t_aw = 0, t_w = 0;
   bit own_wr = 0, last_m = 1, exp_err = 0;
   int n_aw = 0, n_w = 0, n_ar = 0;
   int log_p[$], log_d[$];
   bit log_w[$];
   logic [1:0] g_seen = '0, last_resp = '0;
   logic [31:0] last_rdata = '0;
   bit [1:0] drop_aw = '0, drop_w = '0, drop_ar = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial forever begin
      @(negedge bus_clk);
      cyc++;
      if (bus_rst) begin
         {m_awready, m_wready, m_arready, m_bvalid, m_rvalid} = '0;
         b_pend = 0; r_pend = 0;
         aw_wait = aw_dly; w_wait = w_dly; ar_wait = ar_dly;
      end else begin
         if (m_if.awvalid) begin
            if (aw_wait == 0) m_awready = 1; else begin m_awready = 0; aw_wait--; end
         end else begin m_awready = 0; aw_wait = aw_dly; end
         if (m_if.wvalid) begin
            if (w_wait == 0) m_wready = 1; else begin m_wready = 0; w_wait--; end
         end else begin m_wready = 0; w_wait = w_dly; end
         if (m_if.arvalid) begin
            if (ar_wait == 0) m_arready = 1; else begin m_arready = 0; ar_wait--; end
         end else begin m_arready = 0; ar_wait = ar_dly; end
         m_bvalid = 0;
         if (b_pend) begin if (b_wait == 0) m_bvalid = 1; else b_wait--; end
         m_rvalid = 0;
         m_rdata  = r_val;
         if (r_pend && !r_never) begin if (r_wait == 0) m_rvalid = 1; else r_wait--; end
      end
      #1;
      if (bus_rst) begin
         check("rst_quiet", {o_awready, o_wready, o_arready, o_bvalid, o_rvalid,
               m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.bready, m_if.rready}, '0);
         owner = -1; last_m = 1; n_aw = 0; n_w = 0; n_ar = 0;
      end else begin
         check("grant", grant, owner < 0 ? 2'b00 : (owner == 0 ? 2'b01 : 2'b10));
         g_seen = g_seen | grant;
         for (int p = 0; p < 2; p++)
            if (p != owner)
               check($sformatf("idle_port%0d", p),
                     {o_awready[p], o_wready[p], o_arready[p], o_bvalid[p], o_rvalid[p]}, '0);
         if (owner < 0)
            check("m_quiet", {m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.bready, m_if.rready}, '0);
         for (int p = 0; p < 2; p++) begin
            if (s_awv[p] && o_awready[p]) drop_aw[p] = 1;
            if (s_wv[p] && o_wready[p])   drop_w[p]  = 1;
            if (s_arv[p] && o_arready[p]) drop_ar[p] = 1;
         end
         if (owner >= 0) begin
            if (m_if.awvalid && m_awready) begin
               n_aw++; t_aw = cyc;
               check("aw_in_write", own_wr, 1);
               check("awaddr", m_if.awaddr, s_awaddr[owner]);
            end
            if (m_if.wvalid && m_wready) begin
               n_w++; t_w = cyc;
               check("wdata", {m_if.wstrb, m_if.wdata}, {s_wstrb[owner], s_wdata[owner]});
            end
            if ((m_if.awvalid && m_awready) || (m_if.wvalid && m_wready))
               if (n_aw == 1 && n_w == 1) begin b_pend = 1; b_wait = b_dly; end
            if (m_if.arvalid && m_arready) begin
               n_ar++;
               check("ar_in_read", own_wr, 0);
               check("araddr", m_if.araddr, s_araddr[owner]);
               r_pend = 1; r_wait = r_dly; r_val = 32'hC0DE_0000 + r_seq; r_seq++;
`ifdef QSFP_AXIL_TIMEOUT_EN
               exp_err = r_never;
`endif
            end
            if (m_bvalid && m_if.bready) b_pend = 0;
            if (m_rvalid && m_if.rready) r_pend = 0;
            if (o_bvalid[owner] || o_rvalid[owner]) begin
               check("resp_kind", o_bvalid[owner], own_wr);
               if (o_bvalid[owner]) begin
                  last_resp = o_bresp[owner];
                  check("bresp", o_bresp[owner], exp_err ? 2'b10 : 2'b00);
                  if (!exp_err) check("wr_hs_count", {n_aw[7:0], n_w[7:0], n_ar[7:0]}, 24'h010100);
               end else begin
                  last_resp = o_rresp[owner]; last_rdata = o_rdata[owner];
                  check("rresp", o_rresp[owner], exp_err ? 2'b10 : 2'b00);
                  check("rdata", o_rdata[owner], exp_err ? 32'hDEAD_BEEF : r_val);
                  if (!exp_err) check("rd_hs_count", {n_aw[7:0], n_w[7:0], n_ar[7:0]}, 24'h000001);
               end
               log_p.push_back(owner); log_w.push_back(own_wr); log_d.push_back(t_w - t_aw);
               last_m = owner[0]; owner = -1; b_pend = 0; r_pend = 0;
            end
         end else begin
            bit [1:0] pw, pd;
            int pri, win;
            pw = s_awv & s_wv;
            pd = pw | s_arv;
            if (pd != 0) begin
               pri = last_m ? 0 : 1;
               win = pd[pri] ? pri : 1 - pri;
               owner = win; own_wr = pw[win];
               n_aw = 0; n_w = 0; n_ar = 0; exp_err = 0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge bus_clk);
      #1;
      for (int p = 0; p < 2; p++) begin
         if (drop_aw[p]) begin s_awv[p] = 0; drop_aw[p] = 0; end
         if (drop_w[p])  begin s_wv[p]  = 0; drop_w[p]  = 0; end
         if (drop_ar[p]) begin s_arv[p] = 0; drop_ar[p] = 0; end
      end
   endtask

   task automatic wr(input int p, input logic [AW-1:0] a, input logic [31:0] d);
      s_awaddr[p] = a; s_wdata[p] = d; s_wstrb[p] = 4'hF; s_awv[p] = 1; s_wv[p] = 1;
   endtask

   task automatic rd(input int p, input logic [AW-1:0] a);
      s_araddr[p] = a; s_arv[p] = 1;
   endtask

   task automatic wait_idle(input string name, input int bound);
      int k;
      k = 0;
      do begin tick(); k++; end
      while (!(owner < 0 && s_awv == 0 && s_wv == 0 && s_arv == 0) && k < bound);
      check({name, "_timeout"}, k >= bound, 0);
   endtask

   task automatic clear_log();
      log_p.delete(); log_w.delete(); log_d.delete(); g_seen = '0;
   endtask

   task automatic do_reset();
      bus_rst = 1; s_awv = '0; s_wv = '0; s_arv = '0;
      tick(); tick();
      bus_rst = 0; drop_aw = '0; drop_w = '0; drop_ar = '0;
      tick();
   endtask

   initial begin
      for (int p = 0; p < 2; p++) begin
         s_awaddr[p] = '0; s_araddr[p] = '0; s_wdata[p] = '0; s_wstrb[p] = '0;
      end
      repeat (3) tick();
      check("reset_grant", grant, 2'b00);
      bus_rst = 0;
      tick();

      // lone s0 write
      wr(0, 40'h10, 32'hA5A5_A5A5);
      wait_idle("t1", 50);
      check("t1_count", log_p.size(), 1);
      check("t1_port_kind", {log_p[0][0], log_w[0]}, 2'b01);
      check("t1_bresp", last_resp, 2'b00);
      check("t1_grant_seen", g_seen, 2'b01);
      clear_log();

      // simultaneous reads after reset alternate 0,1,0,1
      do_reset();
      rd(0, 40'h100); rd(1, 40'h200);
      wait_idle("t2a", 50);
      rd(0, 40'h104); rd(1, 40'h204);
      wait_idle("t2b", 50);
      check("t2_count", log_p.size(), 4);
      for (int i = 0; i < 4; i++) check($sformatf("t2_order%0d", i), log_p[i], i % 2);
      clear_log();

      // s1 write and read together: write first
      wr(1, 40'h20, 32'h1234_5678); rd(1, 40'h24);
      wait_idle("t3", 60);
      check("t3_count", log_p.size(), 2);
      check("t3_seq", {log_p[0][0], log_w[0], log_p[1][0], log_w[1]}, 4'b1110);
      clear_log();

      // skewed aw/w acceptance
      aw_dly = 0; w_dly = 3; wr(0, 40'h30, 32'h0000_0001); wait_idle("t4a", 50);
      aw_dly = 3; w_dly = 0; wr(0, 40'h34, 32'h0000_0002); wait_idle("t4b", 50);
      aw_dly = 1; w_dly = 1; wr(0, 40'h38, 32'h0000_0003); wait_idle("t4c", 50);
      aw_dly = 0; w_dly = 0;
      check("t4_count", log_p.size(), 3);
      check("t4_skew0", log_d[0], 3);
      check("t4_skew1", log_d[1], -3);
      check("t4_skew2", log_d[2], 0);
      clear_log();

      // downstream never answers a read
      r_never = 1;
      rd(1, 40'h300);
`ifdef QSFP_AXIL_TIMEOUT_EN
      wait_idle("t5", 60);
      check("t5_count", log_p.size(), 1);
      check("t5_rresp", last_resp, 2'b10);
      check("t5_rdata", last_rdata, 32'hDEAD_BEEF);
      r_never = 0;
`else
      repeat (1000) tick();
      check("t5_grant", grant, 2'b10);
      check("t5_count", log_p.size(), 0);
      check("t5_rready", m_if.rready, 1'b1);
      r_never = 0;
      do_reset();
`endif
      clear_log();

      // reset while waiting for the write response
      b_dly = 20;
      wr(0, 40'h40, 32'hCAFE_F00D);
      for (int k = 0; k < 30 && !b_pend; k++) tick();
      check("t6_in_wr_resp", b_pend, 1);
      tick(); tick();
      bus_rst = 1;
      tick();
      bus_rst = 0;
      check("t6_grant", grant, 2'b00);
      check("t6_quiet", {o_bvalid, o_rvalid, m_if.awvalid, m_if.wvalid, m_if.arvalid}, '0);
      b_dly = 0;
      tick();
      rd(1, 40'h50);
      wait_idle("t6", 50);
      check("t6_count", log_p.size(), 1);
      check("t6_port_kind", {log_p[0][0], log_w[0]}, 2'b10);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/x4xx_qsfp_axil_arbiter.md
X4XX_QSFP_AXIL_ARBITER -- requirements
Module: x4xx_qsfp_axil_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 40: AXI-Lite address width on all ports.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024: downstream response timeout in bus_clk cycles; used only when the timeout macro is defined.
REQ-003 SHALL have port bus_clk, input, 1: the only clock; all logic is synchronous to it.
REQ-004 SHALL have port bus_rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have slave write-address channel s{0,1}_axi_aw*: awaddr (input, ADDR_W), awvalid (input, 1), awready (output, 1).
REQ-006 SHALL have slave write-data channel s{0,1}_axi_w*: wdata (input, 32), wstrb (input, 4), wvalid (input, 1), wready (output, 1).
REQ-007 SHALL have slave write-response channel s{0,1}_axi_b*: bresp (output, 2), bvalid (output, 1), bready (input, 1).
REQ-008 SHALL have slave read-address channel s{0,1}_axi_ar*: araddr (input, ADDR_W), arvalid (input, 1), arready (output, 1).
REQ-009 SHALL have slave read-data channel s{0,1}_axi_r*: rdata (output, 32), rresp (output, 2), rvalid (output, 1), rready (input, 1).
REQ-010 SHALL have master port m_axi_*, carrying the same five channels with directions mirrored, connected to the QSFP wrapper register port.
REQ-011 SHALL have port grant, output, 2: one-hot owner of the transaction in flight; 2'b00 when idle.

Function
REQ-012 SHALL be a single-transaction arbiter with states IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA and ERR_RESP.
REQ-013 SHALL treat a requester as having a pending write when awvalid && wvalid, and a pending read when arvalid.
REQ-014 SHALL, in IDLE, select a requester by round-robin: priority goes to the port that was not served last, and last-served resets to 1 so that port 0 wins first.
REQ-015 SHALL, within the selected requester, take the write before the read when both are pending.
REQ-016 SHALL move IDLE to WR_ADDR or RD_ADDR in the cycle after the decision; grant becomes valid in that same cycle.
REQ-017 SHALL, in WR_ADDR, forward the granted aw and w channels to the master combinationally: valid, data and ready pass through, and the non-granted port sees ready=0.
REQ-018 SHALL track the aw and w handshakes independently and enter WR_RESP only after both have completed; they may complete in either order or in the same cycle.
REQ-019 SHALL, in WR_RESP and RD_DATA, route b or r from the master to the granted slave only, and return to IDLE on the slave-side bvalid&&bready or rvalid&&rready.
REQ-020 SHALL, in RD_ADDR, pass through the granted ar channel and enter RD_DATA on the ar handshake.
REQ-021 SHALL update last-served on completion only, then return to IDLE; minimum spacing between transactions is one IDLE cycle.
REQ-022 SHALL NOT let a requester that deasserts valid before its handshake hang the FSM; the transaction stays owned until completed (AXI forbids valid withdrawal).
REQ-023 SHALL keep all slave ready/valid outputs low and the master valid outputs low outside their active state.

Reset
REQ-024 SHALL, while bus_rst is asserted, put the FSM in IDLE, set grant=0, set last-served=1, clear the aw/w done flags and the timeout counter, and drive every valid/ready output 0.
REQ-025 SHALL, on reset mid-transaction, abandon the transaction with no response issued; the downstream block is in the same reset domain.

Configuration
REQ-026 SHALL support macro QSFP_AXIL_TIMEOUT_EN, defined: a counter runs in every non-IDLE state; at TIMEOUT_CYC cycles without completion it enters ERR_RESP, drives master valids 0, and returns bresp/rresp=2'b10 (SLVERR) with rdata=32'hDEADBEEF to the granted slave, then goes to IDLE on that handshake.
REQ-027 SHALL, with QSFP_AXIL_TIMEOUT_EN undefined, omit the counter and ERR_RESP entirely and wait indefinitely.
REQ-028 SHALL reset the counter on every master-side handshake.

Verification
REQ-029 SHALL cover: s0 write 0x10=0xA5A5A5A5 alone -> one m_axi write, s0 bvalid with bresp=0, grant 2'b01 during the transfer.
REQ-030 SHALL cover: s0 and s1 raise reads in the same cycle after reset -> s0 served first, then s1; repeated, they alternate 0,1,0,1.
REQ-031 SHALL cover: s1 with both write and read pending -> write completes before ar is forwarded.
REQ-032 SHALL cover: master awready 3 cycles before wready, then the reverse, then the same cycle -> exactly one write each, with no duplicate handshake.
REQ-033 SHALL cover: with the macro defined and TIMEOUT_CYC=16, master never asserts rvalid -> SLVERR with rdata=0xDEADBEEF at cycle 16, FSM in IDLE; undefined -> still in RD_DATA at 1000 cycles.
REQ-034 SHALL cover: bus_rst asserted during WR_RESP -> next cycle grant=0, all valids 0, and a new s1 read is served normally.
